// File: rtl/pulse_pkg.sv
// pulse_pkg: shared FSM state encoding and default parameters for pulse_destretch
package pulse_pkg;
  typedef enum logic [1:0] {IDLE, MEAS, LONG} state_t;
  localparam int MIN_W_DEF = 3;
  localparam int MAX_W_DEF = 16;
  localparam int SYNC_STAGES_DEF = 2;
endpackage

// File: rtl/sync_ff.sv
// sync_ff: STAGES-deep flop chain synchronizer; ports clk, rst_n (async low), d (async in), q (synchronized out)
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] r;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r <= '0;
    else r <= {r[STAGES-2:0], d};
  assign q = r[STAGES-1];
endmodule

// File: rtl/pulse_destretch.sv
// pulse_destretch: width-qualifies a synchronized input pulse into one-cycle pulse/err_short/err_long strobes; ports clk, rst_n (async low), in, clr_cnt, pulse, err_short, err_long, busy, evt_cnt, err_cnt
module pulse_destretch
  import pulse_pkg::*;
#(
  parameter int MIN_W = MIN_W_DEF,
  parameter int MAX_W = MAX_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in,
  input  logic        clr_cnt,
  output logic        pulse,
  output logic        err_short,
  output logic        err_long,
  output logic        busy,
  output logic [15:0] evt_cnt,
  output logic [7:0]  err_cnt
);
  localparam int WW = $clog2(MAX_W + 2);
  localparam logic [WW-1:0] MAXV = WW'(MAX_W);
  localparam logic [WW-1:0] MINV = WW'(MIN_W);
  logic s, p_d, sh_d, lg_d;
  state_t st, nst;
  logic [WW-1:0] wcnt, nwcnt;
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst_n(rst_n), .d(in), .q(s));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      wcnt <= '0;
    end else begin
      st <= nst;
      wcnt <= nwcnt;
    end
  always_comb begin
    nst = st == IDLE ? (s ? MEAS : IDLE)
        : st == MEAS ? (!s ? IDLE : wcnt == MAXV ? LONG : MEAS)
        : (s ? LONG : IDLE);
    nwcnt = st == IDLE ? (s ? WW'(1) : '0)
          : (st == MEAS && s && wcnt < MAXV) ? wcnt + 1'b1 : wcnt;
  end
  always_comb begin
    p_d  = st == MEAS && !s && wcnt >= MINV;
    sh_d = st == MEAS && !s && wcnt < MINV;
    lg_d = st == MEAS && s && wcnt == MAXV;
    busy = st != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pulse <= 1'b0;
      err_short <= 1'b0;
      err_long <= 1'b0;
      evt_cnt <= '0;
      err_cnt <= '0;
    end else begin
      pulse <= p_d;
      err_short <= sh_d;
      err_long <= lg_d;
      evt_cnt <= clr_cnt ? '0 : (p_d && evt_cnt != '1) ? evt_cnt + 1'b1 : evt_cnt;
      err_cnt <= clr_cnt ? '0 : ((sh_d || lg_d) && err_cnt != '1) ? err_cnt + 1'b1 : err_cnt;
    end
endmodule

// File: tb/tb_pulse_destretch.sv
// tb_pulse_destretch: directed self-checking bench for pulse_destretch
module tb_pulse_destretch;
  logic clk = 0, rst_n = 0, in_s = 0, clr_cnt = 0;
  logic pulse, err_short, err_long, busy;
  logic [15:0] evt_cnt;
  logic [7:0] err_cnt;
  int checks = 0, errors = 0;
  int cyc = 0, rise_c = 0, fall_c = 0;
  int n_pulse = 0, n_short = 0, n_long = 0, ovl = 0;
  int t_pulse = 0, t_short = 0, t_long = 0;
  pulse_destretch dut (
    .clk(clk), .rst_n(rst_n), .in(in_s), .clr_cnt(clr_cnt),
    .pulse(pulse), .err_short(err_short), .err_long(err_long), .busy(busy),
    .evt_cnt(evt_cnt), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (pulse) begin n_pulse++; t_pulse = cyc; end
    if (err_short) begin n_short++; t_short = cyc; end
    if (err_long) begin n_long++; t_long = cyc; end
    if (int'(pulse) + int'(err_short) + int'(err_long) > 1) ovl++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic hi(input int w);
    @(posedge clk); #1 in_s = 1; rise_c = cyc;
    repeat (w) @(posedge clk);
  endtask
  task automatic lo(input int l);
    #1 in_s = 0; fall_c = cyc;
    repeat (l) @(posedge clk);
  endtask
  initial begin
    #3;
    chk("rst_pulse", pulse, 0);
    chk("rst_short", err_short, 0);
    chk("rst_long", err_long, 0);
    chk("rst_busy", busy, 0);
    chk("rst_evt", evt_cnt, 0);
    chk("rst_err", err_cnt, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (3) @(posedge clk);
    hi(3); lo(10);
    chk("w3_npulse", n_pulse, 1);
    chk("w3_lat", t_pulse - fall_c, 3);
    chk("w3_evt", evt_cnt, 1);
    chk("w3_err", err_cnt, 0);
    hi(2); lo(10);
    chk("w2_nshort", n_short, 1);
    chk("w2_lat", t_short - fall_c, 3);
    chk("w2_npulse", n_pulse, 1);
    chk("w2_err", err_cnt, 1);
    hi(30);
    chk("w30_busy_hi", busy, 1);
    lo(10);
    chk("w30_nlong", n_long, 1);
    chk("w30_when", t_long - rise_c, 19);
    chk("w30_npulse", n_pulse, 1);
    chk("w30_err", err_cnt, 2);
    chk("w30_busy_lo", busy, 0);
    hi(16); lo(8);
    chk("w16_npulse", n_pulse, 2);
    chk("w16_evt", evt_cnt, 2);
    hi(17); lo(8);
    chk("w17_nlong", n_long, 2);
    chk("w17_npulse", n_pulse, 2);
    chk("w17_err", err_cnt, 3);
    hi(4); lo(1); hi(4); lo(8);
    chk("b2b_npulse", n_pulse, 4);
    chk("b2b_evt", evt_cnt, 4);
    @(posedge clk); #1 clr_cnt = 1;
    @(posedge clk); #1 clr_cnt = 0;
    chk("clr_evt", evt_cnt, 0);
    chk("clr_err", err_cnt, 0);
    @(posedge clk); #1 force dut.evt_cnt = 16'hFFFE;
    @(negedge clk); release dut.evt_cnt;
    hi(3); lo(8);
    chk("sat_first", evt_cnt, 16'hFFFF);
    hi(3); lo(8); hi(3); lo(8);
    chk("sat_hold", evt_cnt, 16'hFFFF);
    chk("sat_npulse", n_pulse, 7);
    hi(3); #1 in_s = 0; fall_c = cyc;
    repeat (2) @(posedge clk);
    #1 clr_cnt = 1;
    @(posedge clk); #1 clr_cnt = 0;
    repeat (4) @(posedge clk);
    chk("clrhit_evt", evt_cnt, 0);
    chk("clrhit_npulse", n_pulse, 8);
    chk("clrhit_lat", t_pulse - fall_c, 3);
    hi(3); lo(8);
    chk("pre_rst_evt", evt_cnt, 1);
    @(posedge clk); #1 in_s = 1;
    repeat (4) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_evt", evt_cnt, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pulse", pulse, 0);
    chk("mid_rst_err", err_cnt, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (2) @(posedge clk);
    #1 in_s = 0;
    repeat (10) @(posedge clk);
    chk("mid_rst_npulse", n_pulse, 9);
    chk("mid_rst_evt_after", evt_cnt, 0);
    hi(3); lo(8);
    chk("post_rst_evt", evt_cnt, 1);
    chk("post_rst_npulse", n_pulse, 10);
    chk("excl", ovl, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
